conv_event_sequencer: RTL and testbench

- Parametrised event-driven convolution engine for one spiking conv layer.
- Pops events from the input FIFO and, for each active input channel, performs a read-modify-write on every feature-map location under the KERNEL_SIZE×KERNEL_SIZE neighbourhood, adding kernel weights with saturation.
- On a timestep event it scans the whole feature map, applies threshold/fire/reset and shift-based leak, and pushes spike words to the output FIFO under backpressure.
- Successor to the fixed-mode conv path: adds multi-channel iteration, border clipping, leak and fire scan.

---
 rtl/conv_event_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv_event_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_event_sequencer.sv
// Event-driven spiking convolution sequencer: per-event kernel accumulation into the
// feature map, and on timestep events a threshold/fire/leak scan that emits spike words.
module conv_event_sequencer #(
    parameter int KERNEL_SIZE            = 3,
    parameter int IN_CHANNELS            = 2,
    parameter int OUT_CHANNELS           = 4,
    parameter int IMG_WIDTH              = 8,
    parameter int IMG_HEIGHT             = 8,
    parameter int BITS_PER_COORDINATE    = 3,
    parameter int BITS_PER_KERNEL_WEIGHT = 4,
    parameter int BITS_PER_NEURON        = 8,
    parameter int THRESHOLD              = 16,
    parameter int LEAK_SHIFT             = 2,
    localparam int BPC   = BITS_PER_COORDINATE,
    localparam int BW    = BITS_PER_KERNEL_WEIGHT,
    localparam int BN    = BITS_PER_NEURON,
    localparam int EVT_W = 2 * BPC + IN_CHANNELS + 1,
    localparam int OUT_W = 2 * BPC + OUT_CHANNELS,
    localparam int KA_W  = $clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS),
    localparam int FA_W  = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         evt_valid,
    output logic                         evt_ready,
    input  logic [EVT_W-1:0]             evt_data,
    output logic [KA_W-1:0]              kmem_addr,
    input  logic [OUT_CHANNELS*BW-1:0]   kmem_rdata,
    output logic                         fm_ren,
    output logic [FA_W-1:0]              fm_raddr,
    input  logic [OUT_CHANNELS*BN-1:0]   fm_rdata,
    output logic                         fm_wen,
    output logic [FA_W-1:0]              fm_waddr,
    output logic [OUT_CHANNELS*BN-1:0]   fm_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         busy
);
    // state      | meaning
    // IDLE       | waiting for enable && evt_valid
    // CH_SEL     | pick lowest remaining input channel
    // CONV_ISSUE | read target word and weights, or skip an out-of-bounds offset
    // CONV_WAIT  | memory latency; compute saturated sums
    // CONV_WRITE | write sums, advance kernel offset
    // SCAN_ISSUE | read feature-map word at scan address
    // SCAN_WAIT  | memory latency; compute fire/leak
    // SCAN_WRITE | write fired/leaked word
    // EMIT       | hold spike word until out_ready
    typedef enum logic [3:0] {
        IDLE, CH_SEL, CONV_ISSUE, CONV_WAIT, CONV_WRITE,
        SCAN_ISSUE, SCAN_WAIT, SCAN_WRITE, EMIT
    } state_t;

    localparam int P   = KERNEL_SIZE / 2;
    localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int CHW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int CW  = BPC + 2;
    localparam int OC  = OUT_CHANNELS;
    localparam logic signed [BN-1:0] TH = BN'(THRESHOLD);

    state_t state, state_n;
    logic                ready_en;
    logic [BPC-1:0]      ev_x, ev_y, sx, sy;
    logic [IN_CHANNELS-1:0] mask;
    logic [CHW-1:0]      ch, sel_ch;
    logic                any_ch;
    logic [KW-1:0]       kx, ky;
    logic [OC*BN-1:0]    wdata_q, conv_word, scan_word;
    logic [OC-1:0]       spk_q, scan_spk;
    logic [CW-1:0]       tx, ty;
    logic                in_bnd, last_off, last_addr;
    logic [FA_W-1:0]     tgt_addr, scan_addr;
    logic signed [BN-1:0] v;
    logic signed [BW-1:0] w;
    logic signed [BN:0]   sum;

    assign busy = (state != IDLE);

    assign tx        = CW'(ev_x) + CW'(kx) - CW'(P);
    assign ty        = CW'(ev_y) + CW'(ky) - CW'(P);
    // Negative targets wrap to a set MSB, so one unsigned compare per axis is enough.
    assign in_bnd    = !tx[CW-1] && !ty[CW-1] && (tx < CW'(IMG_WIDTH)) && (ty < CW'(IMG_HEIGHT));
    assign tgt_addr  = FA_W'(ty[BPC-1:0]) * FA_W'(IMG_WIDTH) + FA_W'(tx[BPC-1:0]);
    assign scan_addr = FA_W'(sy) * FA_W'(IMG_WIDTH) + FA_W'(sx);
    assign last_off  = (kx == KW'(KERNEL_SIZE - 1)) && (ky == KW'(KERNEL_SIZE - 1));
    assign last_addr = (sx == BPC'(IMG_WIDTH - 1)) && (sy == BPC'(IMG_HEIGHT - 1));

    always_comb begin
        sel_ch = '0;
        any_ch = 1'b0;
        for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel_ch = CHW'(i);
                any_ch = 1'b1;
            end
        end
    end

    always_comb begin
        conv_word = '0;
        scan_word = '0;
        scan_spk  = '0;
        v   = '0;
        w   = '0;
        sum = '0;
        for (int i = 0; i < OC; i++) begin
            v   = fm_rdata[i*BN +: BN];
            w   = kmem_rdata[i*BW +: BW];
            sum = {v[BN-1], v} + {{(BN + 1 - BW){w[BW-1]}}, w};
            if (sum[BN] != sum[BN-1])
                conv_word[i*BN +: BN] = sum[BN] ? {1'b1, {(BN-1){1'b0}}} : {1'b0, {(BN-1){1'b1}}};
            else
                conv_word[i*BN +: BN] = sum[BN-1:0];
            if (v >= TH)
                scan_spk[i] = 1'b1;
            else
                scan_word[i*BN +: BN] = (LEAK_SHIFT == 0) ? v : v - (v >>> LEAK_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        evt_ready = 1'b0;
        kmem_addr = '0;
        fm_ren    = 1'b0;
        fm_raddr  = '0;
        fm_wen    = 1'b0;
        fm_waddr  = '0;
        fm_wdata  = '0;
        case (state)
            IDLE: begin
                evt_ready = ready_en && enable && evt_valid;
                if (evt_ready) state_n = evt_data[EVT_W-1] ? SCAN_ISSUE : CH_SEL;
            end
            CH_SEL: state_n = any_ch ? CONV_ISSUE : IDLE;
            CONV_ISSUE: begin
                if (in_bnd) begin
                    fm_ren    = 1'b1;
                    fm_raddr  = tgt_addr;
                    kmem_addr = KA_W'(ch) * KA_W'(KERNEL_SIZE * KERNEL_SIZE)
                              + KA_W'(ky) * KA_W'(KERNEL_SIZE) + KA_W'(kx);
                    state_n   = CONV_WAIT;
                end else if (last_off) begin
                    state_n = CH_SEL;
                end
            end
            CONV_WAIT: state_n = CONV_WRITE;
            CONV_WRITE: begin
                fm_wen   = 1'b1;
                fm_waddr = tgt_addr;
                fm_wdata = wdata_q;
                state_n  = last_off ? CH_SEL : CONV_ISSUE;
            end
            SCAN_ISSUE: begin
                fm_ren   = 1'b1;
                fm_raddr = scan_addr;
                state_n  = SCAN_WAIT;
            end
            SCAN_WAIT: state_n = SCAN_WRITE;
            SCAN_WRITE: begin
                fm_wen   = 1'b1;
                fm_waddr = scan_addr;
                fm_wdata = wdata_q;
                if (|spk_q)         state_n = EMIT;
                else if (last_addr) state_n = IDLE;
                else                state_n = SCAN_ISSUE;
            end
            EMIT: if (out_ready) state_n = last_addr ? IDLE : SCAN_ISSUE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            ev_x      <= '0;
            ev_y      <= '0;
            mask      <= '0;
            ch        <= '0;
            kx        <= '0;
            ky        <= '0;
            sx        <= '0;
            sy        <= '0;
            wdata_q   <= '0;
            spk_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: if (evt_ready) begin
                    ev_x <= evt_data[IN_CHANNELS + 2*BPC - 1 -: BPC];
                    ev_y <= evt_data[IN_CHANNELS + BPC - 1 -: BPC];
                    mask <= evt_data[IN_CHANNELS-1:0];
                    sx   <= '0;
                    sy   <= '0;
                end
                CH_SEL: if (any_ch) begin
                    ch <= sel_ch;
                    kx <= '0;
                    ky <= '0;
                end
                CONV_WAIT: wdata_q <= conv_word;
                CONV_ISSUE, CONV_WRITE: if (state == CONV_WRITE || !in_bnd) begin
                    if (kx == KW'(KERNEL_SIZE - 1)) begin
                        kx <= '0;
                        ky <= ky + 1'b1;
                    end else begin
                        kx <= kx + 1'b1;
                    end
                    if (last_off) mask[ch] <= 1'b0;
                end
                SCAN_WAIT: begin
                    wdata_q <= scan_word;
                    spk_q   <= scan_spk;
                end
                SCAN_WRITE, EMIT: begin
                    if (state == SCAN_WRITE && (|spk_q)) begin
                        out_valid <= 1'b1;
                        out_data  <= {sx, sy, spk_q};
                    end else if (state == SCAN_WRITE || out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        if (sx == BPC'(IMG_WIDTH - 1)) begin
                            sx <= '0;
                            sy <= sy + 1'b1;
                        end else begin
                            sx <= sx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_event_sequencer.sv
// Scoreboard bench for conv_event_sequencer: directed events, expected memory writes and
// spike words queued by the stimulus and checked by a negedge monitor.
module tb_conv_event_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, enable, evt_valid, evt_ready, out_ready, out_valid;
    logic [8:0]  evt_data;
    logic [4:0]  kmem_addr;
    logic [15:0] kmem_rdata;
    logic        fm_ren, fm_wen, busy;
    logic [5:0]  fm_raddr, fm_waddr;
    logic [31:0] fm_rdata, fm_wdata;
    logic [9:0]  out_data;

    logic [31:0] fm [64];
    logic [15:0] kw;
    logic        tb_we;
    logic [5:0]  tb_wa;
    logic [31:0] tb_wd;

    typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
    wr_t        wq[$];
    logic [9:0] oq[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_event_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_data(evt_data), .kmem_addr(kmem_addr),
        .kmem_rdata(kmem_rdata), .fm_ren(fm_ren), .fm_raddr(fm_raddr),
        .fm_rdata(fm_rdata), .fm_wen(fm_wen), .fm_waddr(fm_waddr),
        .fm_wdata(fm_wdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always @(posedge clk) begin
        kmem_rdata <= (kmem_addr < 5'd18) ? kw : 16'h0;
        if (fm_ren) fm_rdata <= fm[fm_raddr];
        if (fm_wen) fm[fm_waddr] <= fm_wdata;
        else if (tb_we) fm[tb_wa] <= tb_wd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (fm_wen) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0d data %h", fm_waddr, fm_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("fm_write", {26'b0, fm_waddr, fm_wdata}, {26'b0, e.a, e.d});
                end
            end
            if (out_valid && out_ready) begin
                if (oq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_spike_word: got %h", out_data);
                end else begin
                    chk("out_data", {54'b0, out_data}, {54'b0, oq.pop_front()});
                end
            end
            if (out_valid && !out_ready) chk("stall_no_read", {63'b0, fm_ren}, 64'd0);
        end
    end

    task automatic fm_poke(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic fm_clear();
        for (int a = 0; a < 64; a++) begin
            @(posedge clk); #1;
            tb_we = 1'b1; tb_wa = 6'(a); tb_wd = '0;
        end
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic send_event(input logic [8:0] d);
        int n = 0;
        @(posedge clk); #1;
        evt_valid = 1'b1;
        evt_data  = d;
        @(negedge clk);
        while (!evt_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!evt_ready) chk("evt_ready_timeout", {63'b0, evt_ready}, 64'd1);
        @(posedge clk); #1;
        evt_valid = 1'b0;
    endtask

    // Called #1 after the pop edge; returns the cycle index (pop cycle = 0) where busy is first low.
    task automatic busy_cycles(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int c;
        busy_cycles(c);
        chk("idle_reached", {63'b0, busy}, 64'd0);
    endtask

    task automatic push_scan_64(input logic [5:0] hot, input logic [31:0] hot_d);
        for (int a = 0; a < 64; a++) wq.push_back({6'(a), (6'(a) == hot) ? hot_d : 32'h0});
    endtask

    initial begin
        int cyc;
        logic [7:0] lane;
        rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        kw = 16'h1111;
        evt_valid = 1'b1;
        evt_data  = {1'b0, 3'd2, 3'd5, 2'b00};

        // 1: reset with a pending zero-spike event
        repeat (3) @(negedge clk);
        chk("reset_evt_ready", {63'b0, evt_ready}, 64'd0);
        chk("reset_outputs", {evt_ready, kmem_addr, fm_ren, fm_raddr, fm_wen, fm_waddr,
                              fm_wdata, out_valid, out_data, busy}, 64'd0);
        rst_n = 1'b1;
        #1 chk("evt_ready_at_release", {63'b0, evt_ready}, 64'd0);
        @(posedge clk); #1;
        chk("evt_ready_one_cycle_after", {63'b0, evt_ready}, 64'd1);
        @(posedge clk); #1;
        evt_valid = 1'b0;
        chk("evt_ready_single_pulse", {63'b0, evt_ready}, 64'd0);
        busy_cycles(cyc);
        chk("zero_spike_cycles", 64'(cyc), 64'd2);

        // 2: all weights +1, event (3,3) channel 0
        fm_clear();
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                wq.push_back({6'((2 + ky) * 8 + 2 + kx), 32'h01010101});
        send_event({1'b0, 3'd3, 3'd3, 2'b01});
        busy_cycles(cyc);
        chk("center_event_cycles", 64'(cyc), 64'd30);

        // 3: corner event, both channels
        fm_clear();
        foreach (wq[i]) ;
        for (int c = 1; c <= 2; c++) begin
            wq.push_back({6'd0, {4{8'(c)}}});
            wq.push_back({6'd1, {4{8'(c)}}});
            wq.push_back({6'd8, {4{8'(c)}}});
            wq.push_back({6'd9, {4{8'(c)}}});
        end
        send_event({1'b0, 3'd0, 3'd0, 2'b11});
        busy_cycles(cyc);
        chk("corner_event_cycles", 64'(cyc), 64'd38);

        // 4: positive then negative saturation at (4,4)
        fm_clear();
        kw = 16'h7777;
        for (int n = 1; n <= 20; n++) begin
            lane = (7 * n > 127) ? 8'd127 : 8'(7 * n);
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    wq.push_back({6'((3 + ky) * 8 + 3 + kx), {4{lane}}});
            send_event({1'b0, 3'd4, 3'd4, 2'b01});
            wait_idle();
        end
        chk("sat_pos_cell", {32'b0, fm[36]}, 64'h7F7F7F7F);
        fm_clear();
        kw = 16'h8888;
        for (int n = 1; n <= 20; n++) begin
            lane = (8 * n > 128) ? 8'h80 : 8'(-(8 * n));
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    wq.push_back({6'((3 + ky) * 8 + 3 + kx), {4{lane}}});
            send_event({1'b0, 3'd4, 3'd4, 2'b01});
            wait_idle();
        end
        chk("sat_neg_cell", {32'b0, fm[36]}, 64'h80808080);

        // 5: timestep scan with one firing lane at address 9
        fm_clear();
        fm_poke(6'd9, 32'h00F80F10);
        push_scan_64(6'd9, 32'h00FA0C00);
        oq.push_back({3'd1, 3'd1, 4'b0001});
        send_event({1'b1, 3'd0, 3'd0, 2'b00});
        wait_idle();
        chk("scan_writes_done", 64'(wq.size()), 64'd0);
        chk("scan_words_done", 64'(oq.size()), 64'd0);

        // 6: same scan under backpressure
        fm_clear();
        fm_poke(6'd9, 32'h00F80F10);
        push_scan_64(6'd9, 32'h00FA0C00);
        oq.push_back({3'd1, 3'd1, 4'b0001});
        out_ready = 1'b0;
        send_event({1'b1, 3'd0, 3'd0, 2'b00});
        cyc = 0;
        @(negedge clk);
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("emit_seen", {63'b0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid_held", {63'b0, out_valid}, 64'd1);
            chk("stall_data_stable", {54'b0, out_data}, {54'b0, 3'd1, 3'd1, 4'b0001});
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!fm_ren && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("resume_addr", {58'b0, fm_raddr}, 64'd10);
        wait_idle();
        chk("bp_writes_done", 64'(wq.size()), 64'd0);
        chk("bp_words_done", 64'(oq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
